regfile_wr_arbiter: RTL and testbench

Sequences and shares the register file's single write port and flag port between two requesters.
- EX: execute-stage 8/16-bit results plus flags.
- IDU: 16-bit pair increment/decrement for INC rr, DEC rr, HL+/HL-, SP adjust.

IDU ops are read-modify-write through the regfile's combinational read port 2. Sits between the decode/execute control and regfile.

---
 rtl/regfile_pkg.sv | 32 +++
 rtl/rr_arb2.sv | 44 ++++
 rtl/regfile_wr_arbiter.sv | 126 ++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared encodings, register indices, FSM states and helpers for the regfile write arbiter.
package regfile_pkg;

  localparam logic [1:0] WEN_NONE    = 2'b00;
  localparam logic [1:0] WEN_BYTE    = 2'b01;
  localparam logic [1:0] WEN_PAIR    = 2'b10;
  localparam logic [1:0] WEN_ILLEGAL = 2'b11;

  localparam logic [3:0] REG_PAIR0 = 4'd0;
  localparam logic [3:0] REG_PAIR2 = 4'd2;
  localparam logic [3:0] REG_PAIR4 = 4'd4;
  localparam logic [3:0] REG_PAIR6 = 4'd6;
  localparam logic [3:0] REG_PAIR8 = 4'd8;
  localparam logic [3:0] REG_IDX10 = 4'd10;

  localparam logic [7:0] FLAG_MASK = 8'hF0;

  // Round-robin pointer values
  localparam logic REQ_EX  = 1'b0;
  localparam logic REQ_IDU = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IDU_RD = 2'd1,
    IDU_WR = 2'd2
  } arb_state_t;

  function automatic logic [15:0] pair_step(input logic [15:0] value, input logic dec);
    return dec ? (value - 16'd1) : (value + 16'd1);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way EX/IDU round-robin arbiter producing ready signals.
// With REGFILE_ARB_EX_PRIO_EN defined it becomes fixed EX priority with no pointer.
module rr_arb2
  import regfile_pkg::*;
#(
  parameter logic RESET_FAVOR = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic ex_req,
  input  logic idu_req,
  output logic ex_ready,
  output logic idu_ready
);

`ifdef REGFILE_ARB_EX_PRIO_EN
  assign ex_ready  = enable;
  assign idu_ready = enable && !ex_req;
`else
  logic ptr_reg;
  logic ptr_next;

  // Each side only yields when the other is requesting and holds the pointer
  assign ex_ready  = enable && !(idu_req && (ptr_reg == REQ_IDU));
  assign idu_ready = enable && !(ex_req && (ptr_reg == REQ_EX));

  always_comb begin
    ptr_next = ptr_reg;
    if (ex_req && ex_ready)
      ptr_next = REQ_IDU;
    else if (idu_req && idu_ready)
      ptr_next = REQ_EX;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      ptr_reg <= RESET_FAVOR;
    else
      ptr_reg <= ptr_next;
  end
`endif

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the regfile write/flag ports between EX writes and IDU pair inc/dec.
// Optional fixed EX priority via REGFILE_ARB_EX_PRIO_EN.
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned RR_RESET_FAVOR = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [3:0]  ex_reg,
  input  logic [1:0]  ex_wen,
  input  logic [15:0] ex_data,
  input  logic        ex_flag_en,
  input  logic [7:0]  ex_flag,
  input  logic        idu_valid,
  output logic        idu_ready,
  input  logic [3:0]  idu_reg,
  input  logic        idu_dec,
  output logic        idu_done,
  output logic [15:0] idu_result,
  output logic [3:0]  rf_rdReg2,
  input  logic [7:0]  rf_rdData2,
  input  logic [7:0]  rf_rdData2Lo,
  output logic [1:0]  rf_writeEn,
  output logic [3:0]  rf_wrReg,
  output logic [15:0] rf_wrData,
  output logic        rf_writeFlag,
  output logic [7:0]  rf_flagData,
  output logic        busy
);

  arb_state_t  state_reg;
  logic        dec_reg;
  logic [3:0]  rd_reg_reg;
  logic [1:0]  wen_reg;
  logic [3:0]  wr_reg_reg;
  logic [15:0] wr_data_reg;
  logic        wflag_reg;
  logic [7:0]  flag_data_reg;
  logic        done_reg;
  logic [15:0] result_reg;
  logic [15:0] idu_next;
  logic        arb_enable;
  logic        ex_hs;
  logic        idu_hs;

  // Readies stay low while reset is held, not just after it is sampled
  assign arb_enable = rst && (state_reg == IDLE);

  rr_arb2 #(
    .RESET_FAVOR (RR_RESET_FAVOR != 0)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .enable    (arb_enable),
    .ex_req    (ex_valid),
    .idu_req   (idu_valid),
    .ex_ready  (ex_ready),
    .idu_ready (idu_ready)
  );

  assign ex_hs    = ex_valid && ex_ready;
  assign idu_hs   = idu_valid && idu_ready;
  assign idu_next = pair_step({rf_rdData2, rf_rdData2Lo}, dec_reg);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      dec_reg       <= 1'b0;
      rd_reg_reg    <= 4'd0;
      wen_reg       <= WEN_NONE;
      wr_reg_reg    <= 4'd0;
      wr_data_reg   <= 16'd0;
      wflag_reg     <= 1'b0;
      flag_data_reg <= 8'd0;
      done_reg      <= 1'b0;
      result_reg    <= 16'd0;
    end else begin
      wen_reg       <= WEN_NONE;
      wr_reg_reg    <= 4'd0;
      wr_data_reg   <= 16'd0;
      wflag_reg     <= 1'b0;
      flag_data_reg <= 8'd0;
      done_reg      <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (ex_hs) begin
            wen_reg       <= (ex_wen == WEN_ILLEGAL) ? WEN_NONE : ex_wen;
            wr_reg_reg    <= ex_reg;
            wr_data_reg   <= ex_data;
            wflag_reg     <= ex_flag_en;
            flag_data_reg <= ex_flag & FLAG_MASK;
          end else if (idu_hs) begin
            rd_reg_reg <= {idu_reg[3:1], 1'b0};
            dec_reg    <= idu_dec;
            state_reg  <= IDU_RD;
          end
        end
        // Read data is sampled at the end of IDU_RD and the write lands in IDU_WR
        IDU_RD: begin
          wen_reg     <= WEN_PAIR;
          wr_reg_reg  <= rd_reg_reg;
          wr_data_reg <= idu_next;
          done_reg    <= 1'b1;
          result_reg  <= idu_next;
          state_reg   <= IDU_WR;
        end
        IDU_WR:  state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy         = (state_reg != IDLE);
  assign rf_rdReg2    = rd_reg_reg;
  assign rf_writeEn   = wen_reg;
  assign rf_wrReg     = wr_reg_reg;
  assign rf_wrData    = wr_data_reg;
  assign rf_writeFlag = wflag_reg;
  assign rf_flagData  = flag_data_reg;
  assign idu_done     = done_reg;
  assign idu_result   = result_reg;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter with a small pair-wide regfile model.
module tb_regfile_wr_arbiter;
  import regfile_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_valid = 1'b0, ex_ready, ex_flag_en = 1'b0;
  logic [3:0]  ex_reg = 4'd0;
  logic [1:0]  ex_wen = 2'd0;
  logic [15:0] ex_data = 16'd0;
  logic [7:0]  ex_flag = 8'd0;
  logic        idu_valid = 1'b0, idu_ready, idu_dec = 1'b0, idu_done;
  logic [3:0]  idu_reg = 4'd0;
  logic [15:0] idu_result;
  logic [3:0]  rf_rdReg2, rf_wrReg;
  logic [7:0]  rf_rdData2, rf_rdData2Lo, rf_flagData;
  logic [1:0]  rf_writeEn;
  logic [15:0] rf_wrData;
  logic        rf_writeFlag, busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] pair_mem [0:15];
  logic        pl_en = 1'b0;
  logic [3:0]  pl_idx = 4'd0;
  logic [15:0] pl_val = 16'd0;

  always #5 clk = ~clk;

  regfile_wr_arbiter #(.RR_RESET_FAVOR(0)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_reg(ex_reg), .ex_wen(ex_wen),
    .ex_data(ex_data), .ex_flag_en(ex_flag_en), .ex_flag(ex_flag),
    .idu_valid(idu_valid), .idu_ready(idu_ready), .idu_reg(idu_reg), .idu_dec(idu_dec),
    .idu_done(idu_done), .idu_result(idu_result),
    .rf_rdReg2(rf_rdReg2), .rf_rdData2(rf_rdData2), .rf_rdData2Lo(rf_rdData2Lo),
    .rf_writeEn(rf_writeEn), .rf_wrReg(rf_wrReg), .rf_wrData(rf_wrData),
    .rf_writeFlag(rf_writeFlag), .rf_flagData(rf_flagData), .busy(busy)
  );

  // Regfile model: combinational read, registered write
  assign rf_rdData2   = pair_mem[rf_rdReg2][15:8];
  assign rf_rdData2Lo = pair_mem[rf_rdReg2][7:0];

  always @(posedge clk) begin
    if (pl_en)
      pair_mem[pl_idx] <= pl_val;
    else if (rf_writeEn == WEN_PAIR)
      pair_mem[rf_wrReg] <= rf_wrData;
    else if (rf_writeEn == WEN_BYTE)
      pair_mem[rf_wrReg][7:0] <= rf_wrData[7:0];
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  task automatic preload(input logic [3:0] idx, input logic [15:0] val);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Lone IDU op starting at +1 after an edge; returns at +1 after the edge leaving IDU_WR
  task automatic idu_op(input logic [3:0] reg_in, input logic dec, input logic [15:0] exp);
    logic [3:0] pair;
    pair = {reg_in[3:1], 1'b0};
    idu_valid = 1'b1; idu_reg = reg_in; idu_dec = dec;
    #1;
    check("idu_ready", {15'd0, idu_ready}, 16'd1);
    @(posedge clk); #1;
    idu_valid = 1'b0;
    check("rd busy", {15'd0, busy}, 16'd1);
    check("rd rdReg2", {12'd0, rf_rdReg2}, {12'd0, pair});
    check("rd writeEn", {14'd0, rf_writeEn}, 16'd0);
    check("rd idu_done", {15'd0, idu_done}, 16'd0);
    @(posedge clk); #1;
    check("wr idu_done", {15'd0, idu_done}, 16'd1);
    check("wr idu_result", idu_result, exp);
    check("wr wrData", rf_wrData, exp);
    check("wr writeEn", {14'd0, rf_writeEn}, {14'd0, WEN_PAIR});
    check("wr wrReg", {12'd0, rf_wrReg}, {12'd0, pair});
    check("wr writeFlag", {15'd0, rf_writeFlag}, 16'd0);
    check("wr ex_ready", {15'd0, ex_ready}, 16'd0);
    @(posedge clk); #1;
    check("post busy", {15'd0, busy}, 16'd0);
    check("post idu_done", {15'd0, idu_done}, 16'd0);
    check("post pair", pair_mem[pair], exp);
  endtask

  typedef struct {
    logic [3:0]  reg_idx;
    logic [1:0]  wen;
    logic [15:0] data;
    logic        flag_en;
    logic [7:0]  flag;
    logic [1:0]  exp_wen;
    logic [15:0] exp_data;
    logic        exp_wflag;
    logic [7:0]  exp_fdata;
  } ex_vec_t;

  typedef struct {
    logic ex_rdy;
    logic idu_rdy;
    logic busy;
    logic [1:0] wen;
  } arb_row_t;

  ex_vec_t  ex_vecs [4];
  arb_row_t arb_rows [8];

  initial begin
    ex_vecs[0] = '{4'd3,  2'b01, 16'h00AB, 1'b0, 8'h00, 2'b01, 16'h00AB, 1'b0, 8'h00};
    ex_vecs[1] = '{4'd4,  2'b10, 16'h1234, 1'b1, 8'hA5, 2'b10, 16'h1234, 1'b1, 8'hA0};
    ex_vecs[2] = '{4'd10, 2'b11, 16'hBEEF, 1'b1, 8'hFF, 2'b00, 16'hBEEF, 1'b1, 8'hF0};
    ex_vecs[3] = '{4'd0,  2'b00, 16'h5555, 1'b1, 8'h3C, 2'b00, 16'h5555, 1'b1, 8'h30};
`ifdef REGFILE_ARB_EX_PRIO_EN
    for (int k = 0; k < 8; k++)
      arb_rows[k] = '{1'b1, 1'b0, 1'b0, (k == 0) ? 2'b00 : 2'b01};
`else
    arb_rows[0] = '{1'b1, 1'b0, 1'b0, 2'b00};
    arb_rows[1] = '{1'b0, 1'b1, 1'b0, 2'b01};
    arb_rows[2] = '{1'b0, 1'b0, 1'b1, 2'b00};
    arb_rows[3] = '{1'b0, 1'b0, 1'b1, 2'b10};
    arb_rows[4] = '{1'b1, 1'b0, 1'b0, 2'b00};
    arb_rows[5] = '{1'b0, 1'b1, 1'b0, 2'b01};
    arb_rows[6] = '{1'b0, 1'b0, 1'b1, 2'b00};
    arb_rows[7] = '{1'b0, 1'b0, 1'b1, 2'b10};
`endif

    // Reset held with both requesters active
    ex_valid = 1'b1; idu_valid = 1'b1; ex_wen = 2'b10; ex_data = 16'hFFFF;
    #12;
    check("rst ex_ready", {15'd0, ex_ready}, 16'd0);
    check("rst idu_ready", {15'd0, idu_ready}, 16'd0);
    check("rst busy", {15'd0, busy}, 16'd0);
    check("rst writeEn", {14'd0, rf_writeEn}, 16'd0);
    check("rst wrData", rf_wrData, 16'd0);
    check("rst writeFlag", {15'd0, rf_writeFlag}, 16'd0);
    check("rst idu_done", {15'd0, idu_done}, 16'd0);
    check("rst idu_result", idu_result, 16'd0);
    ex_valid = 1'b0; idu_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;

    // Back-to-back EX vectors
    for (int i = 0; i < 4; i++) begin
      ex_valid = 1'b1; ex_reg = ex_vecs[i].reg_idx; ex_wen = ex_vecs[i].wen;
      ex_data = ex_vecs[i].data; ex_flag_en = ex_vecs[i].flag_en; ex_flag = ex_vecs[i].flag;
      #1;
      check($sformatf("ex%0d ready", i), {15'd0, ex_ready}, 16'd1);
      @(posedge clk); #1;
      check($sformatf("ex%0d writeEn", i), {14'd0, rf_writeEn}, {14'd0, ex_vecs[i].exp_wen});
      check($sformatf("ex%0d wrReg", i), {12'd0, rf_wrReg}, {12'd0, ex_vecs[i].reg_idx});
      check($sformatf("ex%0d wrData", i), rf_wrData, ex_vecs[i].exp_data);
      check($sformatf("ex%0d writeFlag", i), {15'd0, rf_writeFlag}, {15'd0, ex_vecs[i].exp_wflag});
      check($sformatf("ex%0d flagData", i), {8'd0, rf_flagData}, {8'd0, ex_vecs[i].exp_fdata});
    end
    ex_valid = 1'b0; ex_flag_en = 1'b0;
    @(posedge clk); #1;
    check("idle writeEn", {14'd0, rf_writeEn}, 16'd0);
    check("idle writeFlag", {15'd0, rf_writeFlag}, 16'd0);
    check("idle wrData", rf_wrData, 16'd0);

    // IDU arithmetic including wrap-around; reg 9 exercises the ignored bit 0
    preload(4'd4, 16'h12FF);
    idu_op(4'd4, 1'b0, 16'h1300);
    preload(4'd8, 16'h0000);
    idu_op(4'd9, 1'b1, 16'hFFFF);
    preload(4'd2, 16'hFFFF);
    idu_op(4'd2, 1'b0, 16'h0000);

    // EX pair write immediately followed by IDU read of the same pair
    ex_valid = 1'b1; ex_reg = 4'd6; ex_wen = 2'b10; ex_data = 16'h00FE;
    #1;
    check("haz ex_ready", {15'd0, ex_ready}, 16'd1);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    idu_op(4'd6, 1'b0, 16'h00FF);

    // Reset during IDU_RD abandons the op
    idu_valid = 1'b1; idu_reg = 4'd6; idu_dec = 1'b0;
    #1;
    check("ab idu_ready", {15'd0, idu_ready}, 16'd1);
    @(posedge clk); #1;
    idu_valid = 1'b0;
    check("ab rd busy", {15'd0, busy}, 16'd1);
    rst = 1'b0;
    #1;
    check("ab rst busy", {15'd0, busy}, 16'd0);
    check("ab rst writeEn", {14'd0, rf_writeEn}, 16'd0);
    @(posedge clk); #1;
    check("ab rst idu_done", {15'd0, idu_done}, 16'd0);
    check("ab rst writeEn2", {14'd0, rf_writeEn}, 16'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("ab idu_done", {15'd0, idu_done}, 16'd0);
    check("ab writeEn", {14'd0, rf_writeEn}, 16'd0);
    check("ab pair6", pair_mem[6], 16'h00FF);

    // Both requesters held from reset
    ex_valid = 1'b1; ex_reg = 4'd1; ex_wen = 2'b01; ex_data = 16'h0011;
    idu_valid = 1'b1; idu_reg = 4'd0; idu_dec = 1'b0;
    #1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("arb%0d ex_ready", k), {15'd0, ex_ready}, {15'd0, arb_rows[k].ex_rdy});
      check($sformatf("arb%0d idu_ready", k), {15'd0, idu_ready}, {15'd0, arb_rows[k].idu_rdy});
      check($sformatf("arb%0d busy", k), {15'd0, busy}, {15'd0, arb_rows[k].busy});
      check($sformatf("arb%0d writeEn", k), {14'd0, rf_writeEn}, {14'd0, arb_rows[k].wen});
      @(posedge clk); #1;
    end
    ex_valid = 1'b0; idu_valid = 1'b0;
    repeat (4) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
